ghost_direction_mailbox: RTL and testbench
==========================================

# ghost_direction_mailbox

Parametrised, frame-synchronised transfer block for ghost movement directions between the NIOS software and the FPGA ghost/sprite logic. The NIOS writes a packed word of per-ghost direction lanes at any time. The block stages it and commits it atomically on the next frame tick, so sprite logic never sees a half-updated set. Illegal direction codes are rejected per lane, lost updates are counted, and the committed set is read back to the NIOS in the same packed format.

## Interface
Parameters:
- N_GHOSTS, 4: number of ghost lanes.
- DIR_W, 3: direction code width per ghost.
- LANE_W, 4: lane pitch in the packed NIOS word; must be ≥ DIR_W. Bits above DIR_W in each lane are pad.
- CNT_W, 8: overrun counter width.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- nios_dir_in  in  N_GHOSTS*LANE_W  packed staging data; lane i occupies bits [i*LANE_W +: LANE_W].
- nios_wr  in  1  one-cycle strobe that stages nios_dir_in.
- frame_tick  in  1  one-cycle pulse per frame (vsync edge); the commit point.
- status_clr  in  1  clears sticky illegal flags and the overrun counter.
- fpga_dir_out  out  [N_GHOSTS][DIR_W]  committed directions to the ghost logic.
- fpga_dir_update  out  1  one-cycle pulse on the cycle fpga_dir_out changes set.
- nios_dir_rd  out  N_GHOSTS*LANE_W  committed set repacked; pad bits are 0.
- pending  out  1  staged data awaiting commit.
- illegal_flags  out  N_GHOSTS  sticky per-lane illegal-code flags.
- overrun_cnt  out  CNT_W  saturating count of staged words overwritten before commit.

## Operation
- Direction codes: 0 STOP, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT. Codes ≥5 are illegal. Pad bits of nios_dir_in are ignored.
- Stage: when nios_wr=1, stage ← nios_dir_in and pending ← 1.
  - If pending was already 1 and there is no commit this cycle, overrun_cnt increments, saturating at all-ones.
- Commit: when frame_tick=1 and pending=1, each lane is processed independently.
  - Legal code: active[i] ← stage lane i.
  - Illegal code: active[i] is held and illegal_flags[i] ← 1.
  - pending ← 0 and fpga_dir_update ← 1, even if every lane was illegal.
- frame_tick with pending=0: no change and no update pulse.
- nios_wr and frame_tick in the same cycle:
  - The commit uses the old stage contents, if pending was 1.
  - The new word is staged and pending stays or becomes 1.
  - No overrun is counted.
- status_clr: illegal_flags ← 0 and overrun_cnt ← 0.
  - If an illegal commit or overrun event occurs in the same cycle, the clear is applied first and then the event, giving flag=1 and count=1.
- nios_dir_rd is a combinational repack of the active registers, one lane per i with upper LANE_W-DIR_W bits zero.
- Reset values: active all STOP, stage 0, pending 0, fpga_dir_update 0, illegal_flags 0, overrun_cnt 0, nios_dir_rd 0.

## Timing
- Stage latency: pending is high the cycle after the nios_wr edge.
- Commit latency: fpga_dir_out and nios_dir_rd change on the edge that samples frame_tick=1. fpga_dir_update is high for exactly that following cycle.
- Worst case, write-to-visible: one frame plus 1 cycle.
- Reset asserted mid-frame with pending=1: the staged word is discarded. A frame_tick in the same cycle as Reset has no effect.
- No combinational path from nios_wr or frame_tick to any output.

## Structure
- Package ghost_pkg:
  - typedef enum logic [2:0] dir_t with STOP, UP, DOWN, LEFT, RIGHT.
  - default constants N_GHOSTS, DIR_W, LANE_W.
  - function dir_legal(code) returning 1 for codes below 5.
- Sub-module ghost_dir_lane, instantiated N_GHOSTS times by a generate loop. It holds one active register, the legality check and that lane's sticky illegal flag.
- The top level holds stage, pending, overrun counter, update pulse and packing.

## Test plan
- Reset then idle: all outputs 0; a frame_tick with no write gives no update pulse and fpga_dir_out all STOP.
- Write 16'h4321, then frame_tick 10 cycles later: pending 1→0, fpga_dir_out = {4,3,2,1} for ghosts 3..0, one-cycle update pulse, nios_dir_rd = 16'h4321.
- Committed {4,3,2,1}, then write 16'h7F21 and frame_tick:
  - ghosts 0–1 become 1 and 2; ghosts 2–3 hold 3 and 4.
  - illegal_flags = 4'b1100.
  - the pad bit of lane 2 is ignored.
- Three writes 16'h1111, 16'h2222, 16'h3333 before one tick: overrun_cnt = 2 and the committed value is 16'h3333. Then 300 writes with no tick: overrun_cnt saturates at 255.
- nios_wr 16'h4444 in the same cycle as frame_tick with 16'h1111 pending: commits 1111, pending stays 1, overrun_cnt unchanged. The next tick commits 4444.
- status_clr in the same cycle as an overrun: overrun_cnt = 1. Reset while pending=1: pending 0 and the following tick produces no update.

Source files
------------

// File: rtl/ghost_pkg.sv
// Shared definitions for the ghost direction mailbox.
// Provides the direction code enumeration, default geometry constants and
// the direction legality check used by every lane.
package ghost_pkg;

  localparam int unsigned N_GHOSTS = 4;
  localparam int unsigned DIR_W    = 3;
  localparam int unsigned LANE_W   = 4;
  localparam int unsigned CNT_W    = 8;

  // Number of defined direction codes; anything at or above is illegal.
  localparam int unsigned NUM_DIR_CODES = 5;

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  // Returns 1 when the code names a defined direction.
  function automatic logic dir_legal(input logic [31:0] code);
    return code < 32'(NUM_DIR_CODES);
  endfunction

endpackage

// File: rtl/ghost_dir_lane.sv
// One ghost lane: committed direction register, legality check and the
// lane's sticky illegal-code flag.
// Ports:
//   Clk, Reset    clock and synchronous active-high reset
//   commit        frame commit strobe for this cycle
//   status_clr    clears the sticky flag (a same-cycle illegal commit wins)
//   code          staged direction code for this lane
//   active        committed direction
//   illegal_flag  sticky: an illegal code was rejected at a commit
module ghost_dir_lane #(
  parameter int unsigned DIR_W = ghost_pkg::DIR_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             commit,
  input  logic             status_clr,
  input  logic [DIR_W-1:0] code,
  output logic [DIR_W-1:0] active,
  output logic             illegal_flag
);

  logic legal_c;

  assign legal_c = ghost_pkg::dir_legal(32'(code));

  // Illegal codes leave the active direction untouched.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      active       <= DIR_W'(ghost_pkg::STOP);
      illegal_flag <= 1'b0;
    end else begin
      if (commit && legal_c) begin
        active <= code;
      end
      if (commit && !legal_c) begin
        illegal_flag <= 1'b1;
      end else if (status_clr) begin
        illegal_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ghost_direction_mailbox.sv
// Frame-synchronised mailbox carrying ghost directions from the NIOS to the
// sprite logic. A written word is staged and committed atomically on the
// next frame tick; illegal lanes are rejected, lost writes are counted.
// Ports:
//   Clk, Reset       clock and synchronous active-high reset
//   nios_dir_in      packed staging word, lane i at [i*LANE_W +: LANE_W]
//   nios_wr          stages nios_dir_in
//   frame_tick       commit point, one pulse per frame
//   status_clr       clears illegal flags and overrun counter
//   fpga_dir_out     committed directions per ghost
//   fpga_dir_update  pulse on the cycle the committed set changes
//   nios_dir_rd      committed set repacked, pad bits zero
//   pending          staged word awaiting commit
//   illegal_flags    sticky per-lane illegal-code flags
//   overrun_cnt      saturating count of staged words overwritten
module ghost_direction_mailbox #(
  parameter int unsigned N_GHOSTS = ghost_pkg::N_GHOSTS,
  parameter int unsigned DIR_W    = ghost_pkg::DIR_W,
  parameter int unsigned LANE_W   = ghost_pkg::LANE_W,
  parameter int unsigned CNT_W    = ghost_pkg::CNT_W
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic [N_GHOSTS*LANE_W-1:0]         nios_dir_in,
  input  logic                               nios_wr,
  input  logic                               frame_tick,
  input  logic                               status_clr,
  output logic [N_GHOSTS-1:0][DIR_W-1:0]     fpga_dir_out,
  output logic                               fpga_dir_update,
  output logic [N_GHOSTS*LANE_W-1:0]         nios_dir_rd,
  output logic                               pending,
  output logic [N_GHOSTS-1:0]                illegal_flags,
  output logic [CNT_W-1:0]                   overrun_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Only the code bits of each lane are kept; pad bits are dropped at entry.
  logic [N_GHOSTS-1:0][DIR_W-1:0] stage;
  logic                           commit_c;
  logic                           overrun_c;
  logic                           unused_pad;

  assign commit_c  = frame_tick & pending;
  // A write on a commit cycle replaces already-consumed data, so no overrun.
  assign overrun_c = nios_wr & pending & ~frame_tick;

  // Pad bits of the incoming word carry no information.
  always_comb begin
    unused_pad = 1'b0;
    for (int unsigned i = 0; i < N_GHOSTS; i++) begin
      for (int unsigned b = DIR_W; b < LANE_W; b++) begin
        unused_pad = unused_pad ^ nios_dir_in[i*LANE_W + b];
      end
    end
  end

  // Staging register and pending flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stage   <= '0;
      pending <= 1'b0;
    end else begin
      if (nios_wr) begin
        for (int unsigned i = 0; i < N_GHOSTS; i++) begin
          stage[i] <= nios_dir_in[i*LANE_W +: DIR_W];
        end
        pending <= 1'b1;
      end else if (commit_c) begin
        pending <= 1'b0;
      end
    end
  end

  // Update pulse follows every commit, even one where all lanes were illegal.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fpga_dir_update <= 1'b0;
    end else begin
      fpga_dir_update <= commit_c;
    end
  end

  // Saturating overrun counter; a same-cycle event lands after the clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      overrun_cnt <= '0;
    end else if (status_clr) begin
      overrun_cnt <= overrun_c ? CNT_W'(1) : '0;
    end else if (overrun_c && (overrun_cnt != CNT_MAX)) begin
      overrun_cnt <= overrun_cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < int'(N_GHOSTS); g++) begin : g_lane
    ghost_dir_lane #(
      .DIR_W (DIR_W)
    ) u_lane (
      .Clk          (Clk),
      .Reset        (Reset),
      .commit       (commit_c),
      .status_clr   (status_clr),
      .code         (stage[g]),
      .active       (fpga_dir_out[g]),
      .illegal_flag (illegal_flags[g])
    );
  end

  // Repack committed directions into the NIOS lane layout.
  always_comb begin
    nios_dir_rd = '0;
    for (int unsigned i = 0; i < N_GHOSTS; i++) begin
      nios_dir_rd[i*LANE_W +: DIR_W] = fpga_dir_out[i];
    end
  end

endmodule

// File: tb/tb_ghost_direction_mailbox.sv
// Directed bench for ghost_direction_mailbox with a behavioural reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_ghost_direction_mailbox;

  logic             Clk;
  logic             Reset;
  logic [15:0]      nios_dir_in;
  logic             nios_wr;
  logic             frame_tick;
  logic             status_clr;
  logic [3:0][2:0]  fpga_dir_out;
  logic             fpga_dir_update;
  logic [15:0]      nios_dir_rd;
  logic             pending;
  logic [3:0]       illegal_flags;
  logic [7:0]       overrun_cnt;

  int errors = 0;
  int checks = 0;
  bit model_valid = 1'b0;

  // Reference model state
  int m_active [4];
  int m_stage_word;
  bit m_pending;
  bit m_update;
  bit [3:0] m_flags;
  int m_cnt;

  ghost_direction_mailbox dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .nios_dir_in     (nios_dir_in),
    .nios_wr         (nios_wr),
    .frame_tick      (frame_tick),
    .status_clr      (status_clr),
    .fpga_dir_out    (fpga_dir_out),
    .fpga_dir_update (fpga_dir_update),
    .nios_dir_rd     (nios_dir_rd),
    .pending         (pending),
    .illegal_flags   (illegal_flags),
    .overrun_cnt     (overrun_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model: word-level arithmetic on the staged word.
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) m_active[i] = 0;
      m_stage_word = 0;
      m_pending = 0;
      m_update = 0;
      m_flags = 4'b0;
      m_cnt = 0;
      model_valid = 1'b1;
    end else begin
      bit do_commit;
      bit do_ovr;
      do_commit = frame_tick && m_pending;
      do_ovr = nios_wr && m_pending && !frame_tick;
      if (status_clr) begin
        m_flags = 4'b0;
        m_cnt = 0;
      end
      if (do_ovr && m_cnt < 255) m_cnt = m_cnt + 1;
      if (do_commit) begin
        for (int i = 0; i < 4; i++) begin
          int code;
          code = (m_stage_word / (1 << (4 * i))) % 8;
          if (code < 5) m_active[i] = code;
          else m_flags[i] = 1'b1;
        end
      end
      m_update = do_commit;
      if (nios_wr) begin
        m_stage_word = int'(nios_dir_in);
        m_pending = 1;
      end else if (do_commit) begin
        m_pending = 0;
      end
    end
  end

  function automatic int model_rd();
    int v = 0;
    for (int i = 0; i < 4; i++) v = v + m_active[i] * (1 << (4 * i));
    return v;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin
    if (model_valid) begin
      checks++;
      if (int'(nios_dir_rd) != model_rd() || fpga_dir_update != m_update ||
          pending != m_pending || illegal_flags != m_flags ||
          int'(overrun_cnt) != m_cnt) begin
        errors++;
        $display("FAIL model t=%0t rd=%h/%h upd=%b/%b pend=%b/%b flags=%b/%b cnt=%0d/%0d",
                 $time, nios_dir_rd, model_rd(), fpga_dir_update, m_update,
                 pending, m_pending, illegal_flags, m_flags, overrun_cnt, m_cnt);
      end
      checks++;
      for (int i = 0; i < 4; i++) begin
        if (int'(fpga_dir_out[i]) != m_active[i]) begin
          errors++;
          $display("FAIL dir_out lane=%0d got=%0d exp=%0d", i, fpga_dir_out[i], m_active[i]);
          break;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Apply one cycle of inputs; returns at posedge+1.
  task automatic drive(input bit wr, input logic [15:0] d, input bit ft, input bit clr);
    nios_wr = wr;
    nios_dir_in = d;
    frame_tick = ft;
    status_clr = clr;
    @(posedge Clk);
    #1;
    nios_wr = 1'b0;
    nios_dir_in = 16'h0;
    frame_tick = 1'b0;
    status_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    nios_wr = 1'b0;
    nios_dir_in = 16'h0;
    frame_tick = 1'b0;
    status_clr = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Reset state and idle tick
    chk("reset_rd", int'(nios_dir_rd), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_cnt", int'(overrun_cnt), 0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("idle_tick_update", int'(fpga_dir_update), 0);
    chk("idle_tick_dir", int'(fpga_dir_out), 0);

    // Basic commit
    drive(1'b1, 16'h4321, 1'b0, 1'b0);
    chk("stage_pending", int'(pending), 1);
    idle(10);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("commit_rd", int'(nios_dir_rd), 16'h4321);
    chk("commit_update", int'(fpga_dir_update), 1);
    chk("commit_pending", int'(pending), 0);
    chk("commit_lane3", int'(fpga_dir_out[3]), 4);
    idle(1);
    chk("update_one_cycle", int'(fpga_dir_update), 0);

    // Illegal lanes held, pad bit ignored
    drive(1'b1, 16'h7F21, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("illegal_rd", int'(nios_dir_rd), 16'h4321);
    chk("illegal_flags", int'(illegal_flags), 4'b1100);
    chk("illegal_update", int'(fpga_dir_update), 1);

    // Overrun counting
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    chk("clr_flags", int'(illegal_flags), 0);
    drive(1'b1, 16'h1111, 1'b0, 1'b0);
    drive(1'b1, 16'h2222, 1'b0, 1'b0);
    drive(1'b1, 16'h3333, 1'b0, 1'b0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("ovr_cnt2", int'(overrun_cnt), 2);
    chk("ovr_rd", int'(nios_dir_rd), 16'h3333);
    for (int k = 0; k < 300; k++) drive(1'b1, 16'(k % 5), 1'b0, 1'b0);
    chk("ovr_saturate", int'(overrun_cnt), 255);

    // Write coincident with tick
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    drive(1'b1, 16'h1111, 1'b0, 1'b0);
    drive(1'b1, 16'h4444, 1'b1, 1'b0);
    chk("coinc_rd", int'(nios_dir_rd), 16'h1111);
    chk("coinc_pending", int'(pending), 1);
    chk("coinc_cnt", int'(overrun_cnt), 0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("coinc_next_rd", int'(nios_dir_rd), 16'h4444);

    // Clear coincident with overrun
    drive(1'b1, 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 16'h0002, 1'b0, 1'b0);
    drive(1'b1, 16'h0003, 1'b0, 1'b0);
    chk("pre_clr_cnt", int'(overrun_cnt), 2);
    drive(1'b1, 16'h0004, 1'b0, 1'b1);
    chk("clr_ovr_cnt", int'(overrun_cnt), 1);

    // Reset discards the staged word; tick with reset ignored
    Reset = 1'b1;
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    Reset = 1'b0;
    chk("rst_pending", int'(pending), 0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    chk("rst_tick_update", int'(fpga_dir_update), 0);
    chk("rst_tick_rd", int'(nios_dir_rd), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
